cache_fill_fsm: RTL and testbench

- Miss handler between the CPU's I/D caches and the shared multi-cycle, pipelined main memory (16-bit words, byte addresses).
- On a cache miss, fetches the whole 16-byte block (8 words) in address order and drives the cache data-array word writes.
- On the last returned word, drives the single tag-array write.
- Holds the pipeline stalled through `fsm_busy` until the fill completes.

---
 rtl/cache_fill_fsm.sv | 105 ++++++++++
 tb/tb_cache_fill_fsm.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/cache_fill_fsm.sv
`default_nettype none
// ============================================================================
// cache_fill_fsm : fetches a missed cache block word-by-word from pipelined
//                  main memory and drives the data- and tag-array writes.
// Revision 1.0   : initial release
// ============================================================================
module cache_fill_fsm #(
  parameter int WORDS_PER_BLOCK = 8,
  parameter int ADDR_W          = 16
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               miss_detected,
  input  logic [ADDR_W-1:0]                  miss_address,
  input  logic                               memory_data_valid,
  output logic                               fsm_busy,
  output logic                               mem_en,
  output logic                               mem_wr,
  output logic [ADDR_W-1:0]                  memory_address,
  output logic                               write_data_array,
  output logic [$clog2(WORDS_PER_BLOCK)-1:0] fill_word_index,
  output logic                               write_tag_array
);

  localparam int IDX_W = $clog2(WORDS_PER_BLOCK);
  localparam int CNT_W = IDX_W + 1;
  localparam logic [CNT_W-1:0]  C_FULL     = CNT_W'(WORDS_PER_BLOCK);
  localparam logic [CNT_W-1:0]  C_LAST     = CNT_W'(WORDS_PER_BLOCK - 1);
  localparam logic [ADDR_W-1:0] C_OFF_MASK = ADDR_W'(2 * WORDS_PER_BLOCK - 1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    FILL = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [ADDR_W-1:0]  base_q, base_d;
  logic [CNT_W-1:0]   issue_cnt_q, issue_cnt_d;
  logic [CNT_W-1:0]   recv_cnt_q, recv_cnt_d;

  assign mem_wr = 1'b0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      base_q      <= '0;
      issue_cnt_q <= '0;
      recv_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      issue_cnt_q <= issue_cnt_d;
      recv_cnt_q  <= recv_cnt_d;
    end
  end

  always_comb begin
    state_d          = state_q;
    base_d           = base_q;
    issue_cnt_d      = issue_cnt_q;
    recv_cnt_d       = recv_cnt_q;
    fsm_busy         = 1'b0;
    mem_en           = 1'b0;
    memory_address   = '0;
    write_data_array = 1'b0;
    fill_word_index  = '0;
    write_tag_array  = 1'b0;

    case (state_q)
      IDLE: begin
        // Stall in the miss cycle itself, but keep outputs quiet while in reset.
        fsm_busy = miss_detected & rst_n;
        if (miss_detected) begin
          base_d      = miss_address & ~C_OFF_MASK;
          issue_cnt_d = '0;
          recv_cnt_d  = '0;
          state_d     = FILL;
        end
      end

      FILL: begin
        fsm_busy = 1'b1;
        if (issue_cnt_q < C_FULL) begin
          mem_en         = 1'b1;
          memory_address = base_q + ADDR_W'({issue_cnt_q[IDX_W-1:0], 1'b0});
          issue_cnt_d    = issue_cnt_q + 1'b1;
        end
        // A valid with nothing outstanding is dropped rather than counted.
        if (memory_data_valid && (recv_cnt_q < issue_cnt_q)) begin
          write_data_array = 1'b1;
          fill_word_index  = recv_cnt_q[IDX_W-1:0];
          recv_cnt_d       = recv_cnt_q + 1'b1;
          if (recv_cnt_q == C_LAST) begin
            write_tag_array = 1'b1;
            state_d         = IDLE;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_cache_fill_fsm.sv
`default_nettype none
// ============================================================================
// tb_cache_fill_fsm : scoreboard bench for cache_fill_fsm with a 4-cycle
//                     pipelined memory model.
// Revision 1.0      : initial release
// ============================================================================
module tb_cache_fill_fsm;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        miss_detected = 1'b0;
  logic [15:0] miss_address = '0;
  logic        memory_data_valid = 1'b0;
  logic        fsm_busy, mem_en, mem_wr, write_data_array, write_tag_array;
  logic [15:0] memory_address;
  logic [2:0]  fill_word_index;

  cache_fill_fsm #(.WORDS_PER_BLOCK(8), .ADDR_W(16)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .miss_detected     (miss_detected),
    .miss_address      (miss_address),
    .memory_data_valid (memory_data_valid),
    .fsm_busy          (fsm_busy),
    .mem_en            (mem_en),
    .mem_wr            (mem_wr),
    .memory_address    (memory_address),
    .write_data_array  (write_data_array),
    .fill_word_index   (fill_word_index),
    .write_tag_array   (write_tag_array)
  );

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_err = 0;
  int          tags_seen = 0;
  logic [15:0] exp_addr[$];
  logic [2:0]  exp_idx[$];
  logic [3:0]  mem_pipe = '0;
  logic [15:0] max_addr = '0;
  logic        s_busy, s_en, s_wda, s_tag;
  logic [15:0] s_addr;
  logic [2:0]  s_idx;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic start_fill(input logic [15:0] addr);
    logic [15:0] base;
    base = addr & 16'hFFF0;
    for (int i = 0; i < 8; i++) begin
      exp_addr.push_back(base + 16'(2 * i));
      exp_idx.push_back(3'(i));
    end
  endtask

  task automatic flush_expect();
    exp_addr.delete();
    exp_idx.delete();
  endtask

  // One clock cycle: drive inputs, sample combinational outputs, score, advance.
  task automatic run_cycle(input logic rstn_i, input logic miss_i,
                           input logic [15:0] addr_i, input logic extra_vld);
    logic [2:0] e_idx;
    rst_n             = rstn_i;
    miss_detected     = miss_i;
    miss_address      = addr_i;
    memory_data_valid = mem_pipe[3] | extra_vld;
    #1;
    s_busy = fsm_busy; s_en = mem_en; s_wda = write_data_array;
    s_tag  = write_tag_array; s_addr = memory_address; s_idx = fill_word_index;
    check_eq("mem_wr", mem_wr, 0);
    if (mem_en === 1'b1) begin
      if (memory_address > max_addr) max_addr = memory_address;
      if (exp_addr.size() == 0) check_eq("addr_unexpected", mem_en, 0);
      else check_eq("addr", memory_address, exp_addr.pop_front());
    end
    if (write_data_array === 1'b1) begin
      if (exp_idx.size() == 0) check_eq("write_unexpected", write_data_array, 0);
      else begin
        e_idx = exp_idx.pop_front();
        check_eq("idx", fill_word_index, e_idx);
        check_eq("tag_with_word", write_tag_array, e_idx == 3'd7);
      end
    end else begin
      check_eq("tag_without_word", write_tag_array, 0);
    end
    if (write_tag_array === 1'b1) tags_seen++;
    mem_pipe = {mem_pipe[2:0], mem_en === 1'b1};
    @(posedge clk);
    #1;
  endtask

  initial begin
    @(posedge clk);
    #1;

    // Reset held with a pending miss: outputs must stay quiet.
    run_cycle(1'b0, 1'b1, 16'h0000, 1'b0);
    run_cycle(1'b0, 1'b1, 16'h0000, 1'b0);
    check_eq("rst_outputs", {s_busy, s_en, s_wda, s_tag, s_addr, s_idx}, 0);
    start_fill(16'h0000);
    run_cycle(1'b1, 1'b1, 16'h0000, 1'b0);
    check_eq("rel_busy", s_busy, 1);
    repeat (14) run_cycle(1'b1, 1'b0, 16'h0000, 1'b0);
    check_eq("q_empty_rst", exp_addr.size() + exp_idx.size(), 0);

    // Aligned miss: exact cycle timing with 4-cycle memory.
    start_fill(16'h1230);
    for (int c = 0; c <= 13; c++) begin
      run_cycle(1'b1, c == 0, 16'h1230, 1'b0);
      check_eq("t_aligned_busy", s_busy, c <= 12);
      check_eq("t_aligned_en",   s_en,   (c >= 1) && (c <= 8));
      check_eq("t_aligned_wda",  s_wda,  (c >= 5) && (c <= 12));
      check_eq("t_aligned_tag",  s_tag,  c == 12);
    end

    // Spurious valid while idle.
    run_cycle(1'b1, 1'b0, 16'h0000, 1'b1);
    check_eq("idle_valid_wda", s_wda, 0);
    run_cycle(1'b1, 1'b0, 16'h0000, 1'b0);
    check_eq("idle_valid_busy", s_busy, 0);

    // Unaligned miss, miss toggling mid-fill, 9th valid after completion.
    max_addr = '0;
    start_fill(16'h00FB);
    for (int c = 0; c <= 13; c++) begin
      run_cycle(1'b1, (c == 0) || ((c >= 3) && (c <= 6)),
                (c == 0) ? 16'h00FB : 16'hFFFF, c == 13);
      if (c == 13) begin
        check_eq("extra_valid_wda",  s_wda,  0);
        check_eq("extra_valid_busy", s_busy, 0);
      end
    end
    check_eq("unaligned_max_addr", max_addr, 16'h00FE);
    run_cycle(1'b1, 1'b0, 16'h0000, 1'b0);
    check_eq("after_extra_busy", s_busy, 0);

    // Reset at cycle 6 mid-fill; stale valids must be ignored.
    start_fill(16'h2000);
    for (int c = 0; c <= 6; c++) run_cycle(c != 6, c == 0, 16'h2000, 1'b0);
    flush_expect();
    for (int c = 7; c <= 12; c++) begin
      run_cycle(1'b1, 1'b0, 16'h0000, 1'b0);
      check_eq("abort_wda", s_wda, 0);
      check_eq("abort_tag", s_tag, 0);
    end
    start_fill(16'h4000);
    for (int c = 0; c <= 13; c++) run_cycle(1'b1, c == 0, 16'h4000, 1'b0);
    check_eq("q_empty_abort", exp_addr.size() + exp_idx.size(), 0);

    // Back-to-back misses: second accepted in the cycle busy drops.
    start_fill(16'h0010);
    for (int c = 0; c <= 13; c++) begin
      if (c == 13) start_fill(16'h0020);
      run_cycle(1'b1, (c == 0) || (c == 13), (c == 0) ? 16'h0010 : 16'h0020, 1'b0);
      if (c == 13) check_eq("b2b_busy", s_busy, 1);
    end
    run_cycle(1'b1, 1'b0, 16'h0000, 1'b0);
    check_eq("b2b_first_en",   s_en,   1);
    check_eq("b2b_first_addr", s_addr, 16'h0020);
    repeat (14) run_cycle(1'b1, 1'b0, 16'h0000, 1'b0);
    check_eq("q_empty_b2b", exp_addr.size() + exp_idx.size(), 0);
    check_eq("tag_total", tags_seen, 6);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
